// File: rtl/led_pkg.sv
// led_pkg: mode encoding, scan direction constants and mode sequencing for led_pattern_gen.
package led_pkg;
    typedef enum logic [1:0] {
        COUNT    = 2'd0,
        EXTERNAL = 2'd1,
        SCAN     = 2'd2
    } led_mode_t;
    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;
    function automatic led_mode_t next_mode(input led_mode_t m);
        return (m == COUNT) ? EXTERNAL : (m == EXTERNAL) ? SCAN : COUNT;
    endfunction
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control inputs and LED/mode outputs of led_pattern_gen.
interface led_pattern_gen_if #(
    parameter int NO_OF_LEDS = 4,
    parameter int PRESCALE_W = 24,
    parameter int PWM_W      = 4
);
    logic                  mode_switch;
    logic                  ext_counter;
    logic [PRESCALE_W-1:0] prescale_div;
    logic [PWM_W-1:0]      brightness;
    logic [NO_OF_LEDS-1:0] led_out;
    logic [1:0]            mode_out;
    modport master (output mode_switch, ext_counter, prescale_div, brightness, input led_out, mode_out);
    modport slave  (input mode_switch, ext_counter, prescale_div, brightness, output led_out, mode_out);
endinterface

// File: rtl/led_prescaler.sv
// led_prescaler: tick every div+1 cycles; a div lowered below the count fires at once.
module led_prescaler #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] r_cnt;
    assign tick = (r_cnt >= div);
    always_ff @(posedge clk) begin
        r_cnt <= (reset | clear | tick) ? '0 : r_cnt + PRESCALE_W'(1);
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: COUNT/EXTERNAL/SCAN LED pattern generator with prescaled tick.
// Define LED_PWM_EN to gate led_out with a brightness-controlled PWM.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NO_OF_LEDS = 4,
    parameter int PRESCALE_W = 24,
    parameter int PWM_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    led_pattern_gen_if.slave bus
);
    logic                  r_sw_q;
    led_mode_t             r_mode, w_mode_nxt;
    logic [NO_OF_LEDS-1:0] r_pat, w_pat_nxt, r_led;
    logic                  r_dir, w_dir_nxt;
    logic                  w_edge, w_tick, w_gate;

    assign w_edge = bus.mode_switch & ~r_sw_q;

    led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_edge),
        .div   (bus.prescale_div),
        .tick  (w_tick)
    );

    // A mode-change cycle never updates the pattern, except that entering SCAN reloads it.
    always_comb begin
        w_mode_nxt = r_mode;
        w_pat_nxt  = r_pat;
        w_dir_nxt  = r_dir;
        if (w_edge) begin
            w_mode_nxt = next_mode(r_mode);
            if (w_mode_nxt == SCAN) begin
                w_pat_nxt = NO_OF_LEDS'(1);
                w_dir_nxt = UP;
            end
        end else if (r_mode == COUNT) begin
            w_pat_nxt = w_tick ? r_pat + NO_OF_LEDS'(1) : r_pat;
        end else if (r_mode == EXTERNAL) begin
            w_pat_nxt = r_pat + NO_OF_LEDS'(bus.ext_counter);
        end else if (r_mode == SCAN) begin
            if (w_tick && !$onehot(r_pat)) begin
                w_pat_nxt = NO_OF_LEDS'(1);
                w_dir_nxt = UP;
            end else if (w_tick && r_dir == UP) begin
                w_pat_nxt = r_pat << 1;
                w_dir_nxt = r_pat[NO_OF_LEDS-2] ? DOWN : UP;
            end else if (w_tick) begin
                w_pat_nxt = r_pat >> 1;
                w_dir_nxt = r_pat[1] ? UP : DOWN;
            end
        end else begin
            w_mode_nxt = COUNT;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;
    always_ff @(posedge clk) begin
        r_pwm_cnt <= reset ? '0 : r_pwm_cnt + PWM_W'(1);
    end
    assign w_gate = (r_pwm_cnt < bus.brightness);
`else
    logic [PWM_W-1:0] w_unused_brightness;
    assign w_unused_brightness = bus.brightness;
    assign w_gate = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_q <= 1'b1;
            r_mode <= COUNT;
            r_pat  <= '0;
            r_dir  <= UP;
            r_led  <= '0;
        end else begin
            r_sw_q <= bus.mode_switch;
            r_mode <= w_mode_nxt;
            r_pat  <= w_pat_nxt;
            r_dir  <= w_dir_nxt;
            r_led  <= r_pat & {NO_OF_LEDS{w_gate}};
        end
    end

    assign bus.led_out  = r_led;
    assign bus.mode_out = r_mode;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed stimulus with a cycle-level reference model and literal checkpoints.
module tb_led_pattern_gen;
    localparam int N  = 4;
    localparam int PW = 24;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_pattern_gen_if #(.NO_OF_LEDS(N), .PRESCALE_W(PW), .PWM_W(WW)) bus ();
    led_pattern_gen #(.NO_OF_LEDS(N), .PRESCALE_W(PW), .PWM_W(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int m_mode, m_pat, m_pos, m_pre, m_swq, m_led, m_pwm;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scan position p walks 0..2N-3; the lit LED bounces 0..N-1..1.
    function automatic int bounce(input int p);
        return 1 << ((p < N) ? p : 2 * N - 2 - p);
    endfunction

    always @(posedge clk) begin
        int ms, ev, tick, gate;
        if (reset) begin
            m_mode = 0; m_pat = 0; m_pos = 0; m_pre = 0; m_swq = 1; m_led = 0; m_pwm = 0;
        end else begin
            ms   = int'(bus.mode_switch);
            ev   = (ms == 1 && m_swq == 0) ? 1 : 0;
            m_swq = ms;
            tick = (m_pre >= int'(bus.prescale_div)) ? 1 : 0;
`ifdef LED_PWM_EN
            gate = (m_pwm < int'(bus.brightness)) ? 1 : 0;
`else
            gate = 1;
`endif
            m_led = gate ? m_pat : 0;
            m_pwm = (m_pwm + 1) % (1 << WW);
            m_pre = (ev || tick) ? 0 : m_pre + 1;
            if (ev) begin
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 2) begin m_pos = 0; m_pat = 1; end
            end else if (m_mode == 0 && tick) begin
                m_pat = (m_pat + 1) % (1 << N);
            end else if (m_mode == 1) begin
                m_pat = (m_pat + int'(bus.ext_counter)) % (1 << N);
            end else if (m_mode == 2 && tick) begin
                m_pos = (m_pos + 1) % (2 * N - 2);
                m_pat = bounce(m_pos);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_led_out", int'(bus.led_out), m_led);
            check("model_mode_out", int'(bus.mode_out), m_mode);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int len);
        bus.mode_switch = 1'b1;
        cyc(len);
        bus.mode_switch = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[8] = '{1, 2, 4, 8, 4, 2, 1, 2};
        int k, p, a, cnt;
        bus.mode_switch  = 1'b1;
        bus.ext_counter  = 1'b0;
        bus.prescale_div = PW'(3);
        bus.brightness   = '0;
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_led", int'(bus.led_out), 0);
        check("reset_mode", int'(bus.mode_out), 0);
        cyc(3);
        check("held_switch_no_edge", int'(bus.mode_out), 0);
        bus.mode_switch = 1'b0;

        k = 0;
        while (int'(bus.led_out) != 15 && k < 100) begin cyc(1); k++; end
        check("count_reach_15", int'(bus.led_out), 15);
        cyc(3);
        check("count_hold_15", int'(bus.led_out), 15);
        cyc(1);
        check("count_wrap_0", int'(bus.led_out), 0);

        pulse(1);
        check("pulse1_mode", int'(bus.mode_out), 1);
        cyc(2); pulse(1);
        check("pulse2_mode", int'(bus.mode_out), 2);
        cyc(2); pulse(1);
        check("pulse3_mode", int'(bus.mode_out), 0);
        cyc(2); pulse(10);
        check("long_pulse_mode", int'(bus.mode_out), 1);
        cyc(3);
        check("long_pulse_once", int'(bus.mode_out), 1);

        cyc(2);
        p = int'(bus.led_out);
        bus.ext_counter = 1'b1;
        cyc((5 - p) & 15);
        bus.ext_counter = 1'b0;
        cyc(2);
        check("ext_load_5", int'(bus.led_out), 5);
        bus.ext_counter = 1'b1;
        cyc(12);
        bus.ext_counter = 1'b0;
        cyc(2);
        check("ext_wrap_1", int'(bus.led_out), 1);
        cyc(3);
        check("ext_hold_1", int'(bus.led_out), 1);

        bus.prescale_div = '0;
        pulse(1);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check($sformatf("scan_seq%0d", i), int'(bus.led_out), seq[i]);
        end

        pulse(1);
        a = int'(bus.led_out);
        cyc(1);
        check("edge_beats_tick", int'(bus.led_out), a);
        check("scan_to_count", int'(bus.mode_out), 0);

        cyc(2); pulse(1);
        cyc(2); pulse(1);
        cyc(3);
        check("rescan_mode", int'(bus.mode_out), 2);
        reset = 1'b1;
        cyc(1);
        check("mid_reset_led", int'(bus.led_out), 0);
        check("mid_reset_mode", int'(bus.mode_out), 0);
        reset = 1'b0;

`ifdef LED_PWM_EN
        k = 0;
        while (m_pat != 15 && k < 40) begin cyc(1); k++; end
        bus.prescale_div = '1;
        bus.brightness = WW'(4);
        cyc(2);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            if (int'(bus.led_out) == 15) cnt++;
        end
        check("pwm_duty_4", cnt, 8);
        bus.brightness = '0;
        cyc(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (int'(bus.led_out) == 0) cnt++;
        end
        check("pwm_off", cnt, 16);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
